// File: rtl/fruit_ninja_engine.sv
// Fruit-ninja game engine: spawns fruit into a ring of lanes on a fixed
// period, lets a loud-enough mic tone slice the lowest whole fruit, and
// tracks score, lives and game-over for the display logic.

// One fruit slot: empty / whole / sliced plus the fruit kind it holds.
module fruit_ninja_lane #(
  parameter int TYPE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_slice,
  input  logic              i_spawn,
  input  logic [TYPE_W-1:0] i_type,
  output logic              o_whole,
  output logic              o_sliced,
  output logic [TYPE_W-1:0] o_type
);
  typedef enum logic [1:0] {L_EMPTY, L_WHOLE, L_SLICED} lane_t;

  lane_t             r_lane;
  logic [TYPE_W-1:0] r_type;

  // Spawn wins over slice so a lane sliced and respawned together ends whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= L_EMPTY;
      r_type <= '0;
    end else if (i_clear) begin
      r_lane <= L_EMPTY;
      r_type <= '0;
    end else if (i_spawn) begin
      r_lane <= L_WHOLE;
      r_type <= i_type;
    end else if (i_slice) begin
      r_lane <= L_SLICED;
    end
  end

  assign o_whole  = (r_lane == L_WHOLE);
  assign o_sliced = (r_lane == L_SLICED);
  assign o_type   = r_type;
endmodule

module fruit_ninja_engine #(
  parameter int         N_LANES        = 2,
  parameter int         N_TYPES        = 3,
  parameter int         SPAWN_PERIOD   = 2000,
  parameter int         SLICE_COOLDOWN = 250,
  parameter int         FREQ_THRESHOLD = 450,
  parameter int         MAX_LIVES      = 3,
  parameter int         SCORE_W        = 8,
  parameter logic [3:0] GAME_STATE     = 4'b0100,
  parameter logic [3:0] MENU_STATE     = 4'b0000,
  localparam int        TYPE_W         = (N_TYPES > 1) ? $clog2(N_TYPES) : 1,
  localparam int        LIFE_W         = $clog2(MAX_LIVES + 1)
) (
  input  logic                        single_pulse_clk,
  input  logic                        rst_n,
  input  logic [3:0]                  state,
  input  logic                        btnC,
  input  logic [11:0]                 frequency,
  input  logic [11:0]                 raw_mic_data,
  output logic [N_LANES*TYPE_W-1:0]   fruit_type,
  output logic [N_LANES-1:0]          fruit_whole,
  output logic [N_LANES-1:0]          fruit_sliced,
  output logic [SCORE_W-1:0]          score,
  output logic [LIFE_W-1:0]           lives,
  output logic                        fruit_ended,
  output logic                        slice_pulse,
  output logic                        miss_pulse
);
  localparam int TMR_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CD_W  = (SLICE_COOLDOWN > 0) ? $clog2(SLICE_COOLDOWN + 1) : 1;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SPAWN_PERIOD - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_LANES - 1);
  localparam logic [11:0]       FREQ_TH   = FREQ_THRESHOLD[11:0];
  localparam logic [LIFE_W-1:0] LIVES_INI = LIFE_W'(MAX_LIVES);
  // The slicing cycle itself counts as the first cooldown cycle, so the
  // next slice can land exactly SLICE_COOLDOWN cycles after this one.
  localparam logic [CD_W-1:0]   COOL_LOAD = (SLICE_COOLDOWN > 0) ? CD_W'(SLICE_COOLDOWN - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} fsm_t;

  fsm_t               r_state, w_next;
  logic [TMR_W-1:0]   r_timer;
  logic [PTR_W-1:0]   r_ptr;
  logic [CD_W-1:0]    r_cool;
  logic [SCORE_W-1:0] r_score;
  logic [LIFE_W-1:0]  r_lives;
  logic               r_slice_pulse, r_miss_pulse;

  logic               w_clear, w_active, w_spawn, w_slice, w_miss, w_found;
  logic [N_LANES-1:0] w_whole, w_sliced, w_slice_sel, w_spawn_sel;
  logic [TYPE_W-1:0]  w_new_type;

  // FSM state register.
  always_ff @(posedge single_pulse_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state; menu has priority, quit and out-of-lives only act while playing
  // (any other state code pauses the game and holds everything).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (state == GAME_STATE) w_next = S_PLAY;
      S_PLAY: begin
        if (state == MENU_STATE)
          w_next = S_IDLE;
        else if (state == GAME_STATE && (btnC || r_lives == '0))
          w_next = S_OVER;
      end
      S_OVER: if (state == MENU_STATE) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: clear while idle or when heading back to menu, run only in unpaused play.
  always_comb begin
    w_clear     = (r_state == S_IDLE) || (state == MENU_STATE);
    w_active    = (r_state == S_PLAY) && (state == GAME_STATE) && (r_lives != '0);
    fruit_ended = (r_state == S_OVER);
  end

  assign w_spawn    = w_active && (r_timer == TMR_LAST);
  assign w_slice    = w_active && (frequency > FREQ_TH) && (r_cool == '0) && (|w_whole);
  assign w_new_type = TYPE_W'(raw_mic_data % 12'(N_TYPES));

  // Slice target is the lowest-index whole lane, taken from pre-spawn contents.
  always_comb begin
    w_slice_sel = '0;
    w_found     = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (!w_found && w_whole[k]) begin
        w_slice_sel[k] = w_slice;
        w_found        = 1'b1;
      end
    end
  end

  // Decode the spawn pointer into a per-lane spawn strobe.
  always_comb begin
    w_spawn_sel = '0;
    for (int k = 0; k < N_LANES; k++)
      w_spawn_sel[k] = w_spawn && (r_ptr == PTR_W'(k));
  end

  // A whole fruit overwritten by a spawn is a miss unless it was sliced this very cycle.
  assign w_miss = |(w_spawn_sel & w_whole & ~w_slice_sel);

  genvar g;
  generate
    for (g = 0; g < N_LANES; g++) begin : g_lane
      fruit_ninja_lane #(.TYPE_W(TYPE_W)) u_lane (
        .clk      (single_pulse_clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_slice  (w_slice_sel[g]),
        .i_spawn  (w_spawn_sel[g]),
        .i_type   (w_new_type),
        .o_whole  (w_whole[g]),
        .o_sliced (w_sliced[g]),
        .o_type   (fruit_type[g*TYPE_W +: TYPE_W])
      );
    end
  endgenerate

  // Spawn timer and round-robin spawn pointer.
  always_ff @(posedge single_pulse_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_ptr   <= '0;
    end else if (w_clear) begin
      r_timer <= '0;
      r_ptr   <= '0;
    end else if (w_active) begin
      r_timer <= w_spawn ? '0 : r_timer + 1'b1;
      if (w_spawn) r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  // Score, lives and slice cooldown, all saturating.
  always_ff @(posedge single_pulse_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
      r_lives <= LIVES_INI;
      r_cool  <= '0;
    end else if (w_clear) begin
      r_score <= '0;
      r_lives <= LIVES_INI;
      r_cool  <= '0;
    end else if (w_active) begin
      if (w_slice && r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
      if (w_miss && r_lives != '0)               r_lives <= r_lives - 1'b1;
      if (w_slice)                               r_cool  <= COOL_LOAD;
      else if (r_cool != '0)                     r_cool  <= r_cool - 1'b1;
    end
  end

  // Event strobes, one cycle per event and never held through a pause.
  always_ff @(posedge single_pulse_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slice_pulse <= 1'b0;
      r_miss_pulse  <= 1'b0;
    end else begin
      r_slice_pulse <= w_slice;
      r_miss_pulse  <= w_miss;
    end
  end

  assign fruit_whole  = w_whole;
  assign fruit_sliced = w_sliced;
  assign score        = r_score;
  assign lives        = r_lives;
  assign slice_pulse  = r_slice_pulse;
  assign miss_pulse   = r_miss_pulse;
endmodule

// File: tb/tb_fruit_ninja_engine.sv
// Directed bench for fruit_ninja_engine at default parameters.
module tb_fruit_ninja_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic        btnC;
  logic [11:0] frequency, raw_mic_data;
  logic [3:0]  fruit_type;
  logic [1:0]  fruit_whole, fruit_sliced, lives;
  logic [7:0]  score;
  logic        fruit_ended, slice_pulse, miss_pulse;

  int n_cmp = 0;
  int n_err = 0;

  fruit_ninja_engine dut (
    .single_pulse_clk (clk),
    .rst_n            (rst_n),
    .state            (state),
    .btnC             (btnC),
    .frequency        (frequency),
    .raw_mic_data     (raw_mic_data),
    .fruit_type       (fruit_type),
    .fruit_whole      (fruit_whole),
    .fruit_sliced     (fruit_sliced),
    .score            (score),
    .lives            (lives),
    .fruit_ended      (fruit_ended),
    .slice_pulse      (slice_pulse),
    .miss_pulse       (miss_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; state = 4'b0000; btnC = 1'b0; frequency = '0; raw_mic_data = '0;
    #1 rst_n = 1'b0;
    #1;
    // asynchronous reset values, before any clock edge
    chk("rst_whole",  fruit_whole,  2'b00);
    chk("rst_sliced", fruit_sliced, 2'b00);
    chk("rst_type",   fruit_type,   4'h0);
    chk("rst_score",  score,        8'd0);
    chk("rst_lives",  lives,        2'd3);
    chk("rst_ended",  fruit_ended,  1'b0);
    chk("rst_pulses", {slice_pulse, miss_pulse}, 2'b00);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("menu_idle_whole", fruit_whole, 2'b00);

    // first spawn lands on the 2000th play cycle, type 7 % 3 = 1
    state = 4'b0100; raw_mic_data = 12'd7;
    tick(1);
    tick(1999);
    chk("pre_spawn_whole", fruit_whole, 2'b00);
    tick(1);
    chk("spawn1_whole", fruit_whole, 2'b01);
    chk("spawn1_type",  fruit_type,  4'b0001);
    chk("spawn1_miss",  miss_pulse,  1'b0);

    raw_mic_data = 12'd5;  // 5 % 3 = 2
    tick(2000);
    chk("spawn2_whole", fruit_whole, 2'b11);
    chk("spawn2_type",  fruit_type,  4'b1001);

    // slice and spawn coincide on whole lane 0
    tick(1999);
    frequency = 12'd451; raw_mic_data = 12'd3;  // new type 0
    tick(1);
    frequency = 12'd0;
    chk("coin_slice_pulse", slice_pulse, 1'b1);
    chk("coin_miss",        miss_pulse,  1'b0);
    chk("coin_score",       score,       8'd1);
    chk("coin_whole",       fruit_whole, 2'b11);
    chk("coin_sliced",      fruit_sliced, 2'b00);
    chk("coin_type",        fruit_type,  4'b1000);
    chk("coin_lives",       lives,       2'd3);
    tick(1);
    chk("coin_pulse_drop",  slice_pulse, 1'b0);

    // threshold is strict, then two slices exactly 250 cycles apart
    tick(300);
    frequency = 12'd450;
    tick(20);
    chk("thr450_score",  score,        8'd1);
    chk("thr450_sliced", fruit_sliced, 2'b00);
    frequency = 12'd451;
    tick(1);
    chk("sl1_sliced", fruit_sliced, 2'b01);
    chk("sl1_whole",  fruit_whole,  2'b10);
    chk("sl1_score",  score,        8'd2);
    chk("sl1_pulse",  slice_pulse,  1'b1);
    tick(1);
    chk("sl1_pulse_drop", slice_pulse, 1'b0);
    tick(248);
    chk("cool_249_sliced", fruit_sliced, 2'b01);
    chk("cool_249_score",  score,        8'd2);
    tick(1);
    chk("sl2_sliced", fruit_sliced, 2'b11);
    chk("sl2_score",  score,        8'd3);
    chk("sl2_pulse",  slice_pulse,  1'b1);
    frequency = 12'd0;

    // quit, hold for display, back to menu
    btnC = 1'b1;
    tick(1);
    btnC = 1'b0;
    chk("quit_ended", fruit_ended, 1'b1);
    tick(5);
    chk("over_score_held",  score,        8'd3);
    chk("over_sliced_held", fruit_sliced, 2'b11);
    chk("over_ended_held",  fruit_ended,  1'b1);
    state = 4'b0000;
    tick(1);
    chk("menu_ended",  fruit_ended,  1'b0);
    chk("menu_score",  score,        8'd0);
    chk("menu_lives",  lives,        2'd3);
    chk("menu_sliced", fruit_sliced, 2'b00);

    // no slicing: misses on spawns 3..5, game over after lives hit 0
    state = 4'b0100; raw_mic_data = 12'd7;
    tick(1);
    tick(2000);
    chk("ms1_lives", lives, 2'd3);
    tick(2000);
    chk("ms2_whole", fruit_whole, 2'b11);
    chk("ms2_miss",  miss_pulse,  1'b0);
    tick(2000);
    chk("ms3_miss",  miss_pulse, 1'b1);
    chk("ms3_lives", lives,      2'd2);
    tick(1);
    chk("ms3_miss_drop", miss_pulse, 1'b0);
    tick(1999);
    chk("ms4_miss",  miss_pulse, 1'b1);
    chk("ms4_lives", lives,      2'd1);
    tick(2000);
    chk("ms5_miss",  miss_pulse,  1'b1);
    chk("ms5_lives", lives,       2'd0);
    chk("ms5_ended", fruit_ended, 1'b0);
    tick(1);
    chk("ms5_ended_next", fruit_ended, 1'b1);
    tick(2000);
    chk("ms6_no_miss",  miss_pulse,  1'b0);
    chk("ms6_lives",    lives,       2'd0);
    chk("ms6_whole",    fruit_whole, 2'b11);
    chk("ms6_ended",    fruit_ended, 1'b1);

    // build score 5, then reset mid-play
    state = 4'b0000;
    tick(1);
    chk("menu2_lives", lives, 2'd3);
    state = 4'b0100; frequency = 12'd451;
    tick(1);
    tick(10010);
    chk("pre_rst_score", score, 8'd5);
    chk("pre_rst_lives", lives, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_score",  score,        8'd0);
    chk("midrst_whole",  fruit_whole,  2'b00);
    chk("midrst_sliced", fruit_sliced, 2'b00);
    chk("midrst_ended",  fruit_ended,  1'b0);
    state = 4'b0010; frequency = 12'd0;
    rst_n = 1'b1;
    tick(2100);
    chk("wait_game_whole", fruit_whole, 2'b00);
    state = 4'b0100;
    tick(2001);
    chk("restart_whole", fruit_whole, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fruit_ninja_engine.md
FRUIT_NINJA_ENGINE -- requirements
Module: fruit_ninja_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_LANES, 2, number of independent fruit slots on screen (1..8).
- N_TYPES, 3, number of fruit kinds (2..8).
- SPAWN_PERIOD, 2000, clock cycles between spawn events.
- SLICE_COOLDOWN, 250, cycles slicing is disabled after a slice.
- FREQ_THRESHOLD, 450, slice trigger; frequency must be strictly greater.
- MAX_LIVES, 3, lives at game start.
- SCORE_W, 8, score width.
- GAME_STATE, 4'b0100, state code for play.
- MENU_STATE, 4'b0000, state code for menu.
- Derived: TYPE_W = max(1, clog2(N_TYPES)); LIFE_W = clog2(MAX_LIVES+1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- single_pulse_clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- state, in, 4, top-level game state code.
- btnC, in, 1, quit request, level-sampled.
- frequency, in, 12, detected mic frequency.
- raw_mic_data, in, 12, entropy source for fruit type.
- fruit_type, out, N_LANES*TYPE_W, per-lane type; lane k at bits [k*TYPE_W +: TYPE_W].
- fruit_whole, out, N_LANES, lane holds an unsliced fruit.
- fruit_sliced, out, N_LANES, lane holds a sliced fruit.
- score, out, SCORE_W, slices this game.
- lives, out, LIFE_W, remaining lives.
- fruit_ended, out, 1, game finished.
- slice_pulse, out, 1, one-cycle strobe on a slice.
- miss_pulse, out, 1, one-cycle strobe on a miss.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, PLAY, OVER.
REQ-005 IDLE -> PLAY when state == GAME_STATE. On entry: timer = 0; spawn_ptr = 0; all lanes empty; score = 0; lives = MAX_LIVES; cooldown counter = 0, so slicing is enabled.
REQ-006 PLAY -> OVER when btnC = 1, or when lives reaches 0. fruit_ended = 1 in OVER.
REQ-007 PLAY or OVER -> IDLE when state == MENU_STATE. This clears fruit_ended, all lanes, score and cooldown. lives returns to MAX_LIVES.
REQ-008 In PLAY with state other than GAME_STATE or MENU_STATE, the block SHALL hold all registers (pause).
REQ-009 Each lane SHALL be in exactly one of empty, whole or sliced. fruit_whole and fruit_sliced are never both 1 for a lane.
REQ-010 Timer SHALL increment each PLAY cycle. At timer == SPAWN_PERIOD-1 it wraps to 0 and a spawn event occurs in that cycle.
REQ-011 Spawn event on lane spawn_ptr:
- If the lane was whole: miss_pulse = 1 and lives decrements by 1, saturating at 0.
- The lane becomes whole, with type = raw_mic_data % N_TYPES.
- spawn_ptr advances, wrapping from N_LANES-1 to 0.
REQ-012 Slice condition: PLAY, frequency > FREQ_THRESHOLD, cooldown == 0, and at least one lane whole.
REQ-013 On slice:
- The lowest-index whole lane becomes sliced; its type is kept.
- slice_pulse = 1.
- score increments, saturating at 2^SCORE_W-1.
- cooldown loads SLICE_COOLDOWN and decrements once per PLAY cycle to 0.
REQ-014 A slice and a spawn in the same cycle SHALL both apply. The slice is evaluated on pre-spawn lane contents. If both target the same lane: no miss, score increments, and the lane ends the cycle whole with the new type.
REQ-015 A miss that drives lives to 0 SHALL move the FSM to OVER on the next edge. btnC in the same cycle gives the same result.
REQ-016 In OVER, no spawns, slices or counter changes SHALL occur. Lane contents, score and lives are held for display.
REQ-017 slice_pulse and miss_pulse SHALL be registered and high for exactly one cycle per event.

Reset
REQ-018 With rst_n = 0, independent of clock, the block SHALL be in IDLE with:
- all lanes empty, fruit_type = 0;
- score = 0, lives = MAX_LIVES;
- fruit_ended = 0, pulses = 0;
- timer, spawn_ptr and cooldown = 0.
REQ-019 Reset asserted mid-PLAY SHALL abandon the game with no partial update. After release, the block waits for state == GAME_STATE.

Verification
REQ-020 Defaults, raw_mic_data = 7, state = GAME_STATE -> first spawn on the 2000th PLAY cycle: lane 0 whole, type 1, fruit_whole = 2'b01.
REQ-021 Defaults, lanes 0 and 1 whole, frequency = 451 held -> lane 0 sliced, score = 1, slice_pulse one cycle. The next slice (lane 1) occurs exactly 250 cycles later. frequency = 450 never slices.
REQ-022 Defaults, no slicing for 6 spawn events -> miss_pulse at spawns 3, 4 and 5; lives 3 -> 2 -> 1 -> 0; fruit_ended = 1 one cycle after lives = 0; no further spawns.
REQ-023 Slice and spawn coincide on lane 0 while it is whole -> no miss, score increments, lane 0 whole with the new type, lives unchanged.
REQ-024 btnC = 1 mid-PLAY -> OVER, fruit_ended = 1. Then state = MENU_STATE -> IDLE, score = 0, lives = 3, fruit_ended = 0.
REQ-025 rst_n pulsed low mid-PLAY with score = 5 -> immediately score = 0, lanes empty, fruit_ended = 0. Play restarts only when state == GAME_STATE.
